clkgen_bank_drp: RTL and testbench

- Parametrised, cycle-accurate clock-generation bank for the behavioural clocking library; next generation after the fixed six-output PLL model.
- Derives CHANNELS divided clocks from one input clock. Each channel has an independent divide, high time and phase offset, all expressed in input-clock cycles.
- Adds a working dynamic reconfiguration port (DADDR/DI/DEN/DWE/DO/DRDY), a lock sequencer and power-down.
- Used by benches and by designs that need deterministic, reprogrammable clock enables or strobes.

---
 rtl/clkgen_bank_drp.sv | 183 ++++++++++++++++++
 tb/tb_clkgen_bank_drp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_bank_drp.sv
// Clock-generation bank: CHANNELS registered divided clocks derived from CLKIN, each
// with its own divide/high/phase, reprogrammable over a DRP port, with lock sequencing and power-down.
module clkgen_bank_drp #(
    parameter int CHANNELS       = 6,
    parameter int CNT_WIDTH      = 8,
    parameter int DIVIDE_DEFAULT = 4,
    parameter int HIGH_DEFAULT   = 2,
    parameter int PHASE_DEFAULT  = 0,
    parameter int LOCK_CYCLES    = 16
) (
    input  logic                        CLKIN,
    input  logic                        RST,
    input  logic                        PWRDWN,
    input  logic [$clog2(CHANNELS)+1:0] DADDR,
    input  logic [15:0]                 DI,
    input  logic                        DEN,
    input  logic                        DWE,
    output logic [15:0]                 DO,
    output logic                        DRDY,
    output logic [CHANNELS-1:0]         CLKOUT,
    output logic                        LOCKED
);
    localparam int AW = $clog2(CHANNELS) + 2;
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int W  = CNT_WIDTH;

    typedef enum logic [1:0] {LOCKING, RUN, PWRDN} state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] lock_cnt, lock_cnt_nxt;

    logic [W-1:0]  div_r [CHANNELS];
    logic [W-1:0]  high_r [CHANNELS];
    logic [W-1:0]  phase_r [CHANNELS];
    logic [W-1:0]  d_eff [CHANNELS];
    logic [W-1:0]  h_eff [CHANNELS];
    logic [W-1:0]  p_eff [CHANNELS];
    logic [W-1:0]  cnt_r [CHANNELS];
    logic [W-1:0]  cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] wrap_r, wrap_nxt, clk_nxt;

    logic          vld_p0, vld_p1, busy, accept, addr_ok, wr_en;
    logic [AW-1:0] ch_idx;
    logic [15:0]   rd_val, rdata_p0, rdata_p1;
    logic          unused_di;

    function automatic logic [W-1:0] eff_div(input logic [W-1:0] v);
        return (v < W'(2)) ? W'(2) : v;
    endfunction

    function automatic logic [W-1:0] eff_high(input logic [W-1:0] v, input logic [W-1:0] d);
        if (v == '0) return W'(1);
        return (v > d - W'(1)) ? d - W'(1) : v;
    endfunction

    function automatic logic [W-1:0] eff_phase(input logic [W-1:0] v, input logic [W-1:0] d);
        return (v > d - W'(1)) ? d - W'(1) : v;
    endfunction

    // Output level for a channel whose period counter is c; w marks that the counter has wrapped at least once.
    function automatic logic clk_bit(input logic [W-1:0] c, input logic w,
                                     input logic [W-1:0] d, input logic [W-1:0] h,
                                     input logic [W-1:0] p);
        logic [W:0] pos;
        pos = (c >= p) ? {1'b0, c - p} : {1'b0, c} + {1'b0, d} - {1'b0, p};
        return (w || c >= p) && (pos < {1'b0, h});
    endfunction

    assign unused_di = ^DI;
    assign ch_idx    = DADDR >> 2;
    assign addr_ok   = (ch_idx < AW'(CHANNELS)) && (DADDR[1:0] != 2'd3);
    assign busy      = vld_p0 | vld_p1;
    assign accept    = DEN && !busy;
    assign wr_en     = accept && DWE && addr_ok;

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == AW'(c)) begin
                case (DADDR[1:0])
                    2'd0:    rd_val = 16'(div_r[c]);
                    2'd1:    rd_val = 16'(high_r[c]);
                    2'd2:    rd_val = 16'(phase_r[c]);
                    default: rd_val = '0;
                endcase
            end
        end
    end

    // DRP access pipeline: accept edge -> p0 -> p1 -> DRDY two edges later
    always_ff @(posedge CLKIN) begin
        if (RST) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            DRDY   <= 1'b0;
            DO     <= '0;
        end else begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            DRDY   <= vld_p1;
            DO     <= vld_p1 ? rdata_p1 : '0;
        end
    end

    always_ff @(posedge CLKIN) begin
        if (accept) rdata_p0 <= DWE ? '0 : rd_val;
        rdata_p1 <= rdata_p0;
    end

    always_ff @(posedge CLKIN) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (RST) begin
                div_r[c]   <= W'(DIVIDE_DEFAULT);
                high_r[c]  <= W'(HIGH_DEFAULT);
                phase_r[c] <= W'(PHASE_DEFAULT);
            end else if (wr_en && ch_idx == AW'(c)) begin
                case (DADDR[1:0])
                    2'd0:    div_r[c]   <= DI[W-1:0];
                    2'd1:    high_r[c]  <= DI[W-1:0];
                    default: phase_r[c] <= DI[W-1:0];
                endcase
            end
        end
    end

    // Lock sequencer: power-down outranks a write-restart
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        if (PWRDWN) begin
            state_nxt    = PWRDN;
            lock_cnt_nxt = '0;
        end else if (state == PWRDN || wr_en) begin
            state_nxt    = LOCKING;
            lock_cnt_nxt = '0;
        end else if (state == LOCKING) begin
            if (lock_cnt == LW'(LOCK_CYCLES - 1)) state_nxt = RUN;
            else lock_cnt_nxt = lock_cnt + LW'(1);
        end
    end

    always_ff @(posedge CLKIN) begin
        if (RST) begin
            state    <= LOCKING;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Shadow registers only change through a restart, so clamping them continuously equals clamping at start.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            d_eff[c]    = eff_div(div_r[c]);
            h_eff[c]    = eff_high(high_r[c], d_eff[c]);
            p_eff[c]    = eff_phase(phase_r[c], d_eff[c]);
            cnt_nxt[c]  = '0;
            wrap_nxt[c] = 1'b0;
            if (state == RUN) begin
                wrap_nxt[c] = wrap_r[c] | (cnt_r[c] == d_eff[c] - W'(1));
                if (cnt_r[c] != d_eff[c] - W'(1)) cnt_nxt[c] = cnt_r[c] + W'(1);
            end
            clk_nxt[c] = (state_nxt == RUN) &&
                         clk_bit(cnt_nxt[c], wrap_nxt[c], d_eff[c], h_eff[c], p_eff[c]);
        end
    end

    always_ff @(posedge CLKIN) begin
        cnt_r  <= cnt_nxt;
        wrap_r <= wrap_nxt;
    end

    always_ff @(posedge CLKIN) begin
        if (RST) begin
            LOCKED <= 1'b0;
            CLKOUT <= '0;
        end else begin
            LOCKED <= (state_nxt == RUN);
            CLKOUT <= clk_nxt;
        end
    end
endmodule

// File: tb/tb_clkgen_bank_drp.sv
// Bench for clkgen_bank_drp: directed scenarios with literal expectations, then random DRP/power/reset
// traffic checked every cycle against a time-since-restart model of the bank.
module tb_clkgen_bank_drp;
    localparam int CH = 6;
    localparam int LK = 16;

    logic          clk = 1'b0;
    logic          RST, PWRDWN, DEN, DWE;
    logic [4:0]    DADDR;
    logic [15:0]   DI;
    logic [15:0]   DO;
    logic          DRDY, LOCKED;
    logic [CH-1:0] CLKOUT;

    int vectors = 0;
    int miscompares = 0;

    clkgen_bank_drp #(.CHANNELS(CH), .CNT_WIDTH(8), .DIVIDE_DEFAULT(4), .HIGH_DEFAULT(2),
                      .PHASE_DEFAULT(0), .LOCK_CYCLES(LK)) dut (
        .CLKIN(clk), .RST(RST), .PWRDWN(PWRDWN), .DADDR(DADDR), .DI(DI), .DEN(DEN),
        .DWE(DWE), .DO(DO), .DRDY(DRDY), .CLKOUT(CLKOUT), .LOCKED(LOCKED)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file plus "cycles since last (re)start" and pending DRP response.
    int   mem [CH][3];
    int   age = 0, cyc = 0, busy_free = 0, drdy_at = -1, do_val = 0;
    bit   pwr = 0, ready = 0;
    int   m_e, m_ch, m_f, m_n, m_d, m_h, m_p;
    bit   m_acc, m_wv, m_lk;
    logic          exp_locked, exp_drdy;
    logic [CH-1:0] exp_clk;
    logic [15:0]   exp_do;

    always @(posedge clk) begin
        m_e = cyc;
        cyc++;
        if (RST) begin
            for (int c = 0; c < CH; c++) begin
                mem[c][0] = 4; mem[c][1] = 2; mem[c][2] = 0;
            end
            age = 0; pwr = 0; busy_free = 0; drdy_at = -1; ready = 1;
        end else if (ready) begin
            m_acc = DEN && (m_e >= busy_free);
            m_ch  = int'(DADDR) / 4;
            m_f   = int'(DADDR) % 4;
            m_wv  = m_acc && DWE && m_ch < CH && m_f < 3;
            if (m_acc) begin
                do_val    = (!DWE && m_ch < CH && m_f < 3) ? mem[m_ch][m_f] : 0;
                busy_free = m_e + 3;
                drdy_at   = m_e + 2;
            end
            if (m_wv) mem[m_ch][m_f] = int'(DI[7:0]);
            if (PWRDWN || pwr || m_wv) age = 0;
            else age++;
            pwr = PWRDWN;
        end
        m_lk = ready && !pwr && age >= LK;
        m_n  = age - LK;
        exp_locked = m_lk;
        for (int c = 0; c < CH; c++) begin
            m_d = (mem[c][0] < 2) ? 2 : mem[c][0];
            m_h = (mem[c][1] < 1) ? 1 : ((mem[c][1] > m_d - 1) ? m_d - 1 : mem[c][1]);
            m_p = (mem[c][2] > m_d - 1) ? m_d - 1 : mem[c][2];
            exp_clk[c] = m_lk && m_n >= m_p && ((m_n - m_p) % m_d) < m_h;
        end
        exp_drdy = ready && (m_e == drdy_at);
        exp_do   = exp_drdy ? 16'(do_val) : 16'h0;
    end

    always @(negedge clk) begin
        if (ready) begin
            check("LOCKED", 32'(LOCKED), 32'(exp_locked));
            check("CLKOUT", 32'(CLKOUT), 32'(exp_clk));
            check("DRDY", 32'(DRDY), 32'(exp_drdy));
            if (exp_drdy) check("DO", 32'(DO), 32'(exp_do));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_locked(input int max, output int n);
        n = 0;
        while (!LOCKED && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic drp(input int addr, input int data, input bit we, output int rd);
        int k;
        DADDR = 5'(addr); DI = 16'(data); DEN = 1'b1; DWE = we;
        tick();
        DEN = 1'b0; DWE = 1'b0;
        k = 0;
        while (!DRDY && k < 6) begin
            tick();
            k++;
        end
        check("drdy_latency", 32'(k), 32'd2);
        rd = int'(DO);
    endtask

    initial begin
        int n, rd, cnt;
        logic [7:0]  pat8;
        logic [9:0]  pat10a, pat10b;
        logic [11:0] pat12a, pat12b;

        RST = 1'b1; PWRDWN = 1'b0; DEN = 1'b0; DWE = 1'b0; DADDR = '0; DI = '0;
        repeat (3) tick();
        RST = 1'b0;

        // Defaults: lock on the 16th edge, 1100 on every channel
        wait_locked(40, n);
        check("lock_latency", 32'(n), 32'd16);
        pat8 = 8'b11001100;
        for (int i = 0; i < 8; i++) begin
            check("dflt_clk0", 32'(CLKOUT[0]), 32'(pat8[7-i]));
            tick();
        end

        // Write DIVIDE ch0 = 5: restart on the accept edge, DRDY two edges later
        DADDR = 5'd0; DI = 16'd5; DEN = 1'b1; DWE = 1'b1;
        tick();
        DEN = 1'b0; DWE = 1'b0;
        check("wr_locked_drop", 32'(LOCKED), 32'd0);
        check("wr_clk_drop", 32'(CLKOUT), 32'd0);
        check("wr_drdy_p0", 32'(DRDY), 32'd0);
        tick();
        check("wr_drdy_p1", 32'(DRDY), 32'd0);
        tick();
        check("wr_drdy_p2", 32'(DRDY), 32'd1);
        check("wr_do_zero", 32'(DO), 32'd0);
        wait_locked(40, n);
        check("relock_latency", 32'(n + 2), 32'd16);
        pat10a = 10'b1100011000;
        pat10b = 10'b1100110011;
        for (int i = 0; i < 10; i++) begin
            check("div5_clk0", 32'(CLKOUT[0]), 32'(pat10a[9-i]));
            check("div4_clk1", 32'(CLKOUT[1]), 32'(pat10b[9-i]));
            tick();
        end

        // Clamping: ch1 D=6 H=9->5 P=3, ch2 D=0->2
        drp(4, 6, 1, rd);
        drp(5, 9, 1, rd);
        drp(6, 3, 1, rd);
        drp(8, 0, 1, rd);
        wait_locked(40, n);
        check("lock_after_cfg", 32'(n), 32'd14);
        pat12a = 12'b000111110111;
        pat12b = 12'b101010101010;
        for (int i = 0; i < 12; i++) begin
            check("ch1_clamped", 32'(CLKOUT[1]), 32'(pat12a[11-i]));
            check("ch2_div2", 32'(CLKOUT[2]), 32'(pat12b[11-i]));
            tick();
        end
        drp(5, 0, 0, rd);
        check("readback_high_unclamped", 32'(rd), 32'd9);

        // Back-to-back DEN: second one is ignored
        DADDR = 5'd2; DI = 16'd1; DEN = 1'b1; DWE = 1'b1;
        tick();
        DI = 16'd3;
        tick();
        DEN = 1'b0; DWE = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (DRDY) cnt++;
            tick();
        end
        check("b2b_drdy_count", 32'(cnt), 32'd1);
        drp(2, 0, 0, rd);
        check("b2b_first_stored", 32'(rd), 32'd1);

        // Power-down for 5 cycles mid-RUN, with a read serviced while down
        wait_locked(40, n);
        repeat (3) tick();
        PWRDWN = 1'b1;
        tick();
        check("pd_locked", 32'(LOCKED), 32'd0);
        check("pd_clkout", 32'(CLKOUT), 32'd0);
        drp(4, 0, 0, rd);
        check("pd_read", 32'(rd), 32'd6);
        tick();
        PWRDWN = 1'b0;
        // first edge seeing PWRDWN low is the restart edge, then 16 lock cycles
        wait_locked(40, n);
        check("pd_relock", 32'(n), 32'd17);

        // Reset during a pending read, then during LOCKING
        DADDR = 5'd4; DEN = 1'b1; DWE = 1'b0;
        tick();
        DEN = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (DRDY) cnt++;
            tick();
        end
        check("rst_drops_drdy", 32'(cnt), 32'd0);
        drp(4, 0, 0, rd);
        check("rst_default_div", 32'(rd), 32'd4);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        wait_locked(40, n);
        check("rst_relock", 32'(n), 32'd16);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            DEN   = ($urandom_range(0, 24) == 0);
            DWE   = 1'($urandom_range(0, 1));
            DADDR = 5'($urandom_range(0, 31));
            DI    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
            if (PWRDWN) PWRDWN = ($urandom_range(0, 5) != 0);
            else PWRDWN = ($urandom_range(0, 249) == 0);
            RST   = ($urandom_range(0, 799) == 0);
            tick();
        end
        RST = 1'b0; PWRDWN = 1'b0; DEN = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
